pcie_turnoff_ctrl: RTL
======================

# pcie_turnoff_ctrl

Multi-channel PCIe turn-off controller. Tracks outstanding non-posted completions per requester channel, quiesces all channels on a PME_Turn_Off notification, and acknowledges turn-off to the PCIe core once every channel has drained or a drain timeout expires. It sits between the PCIe endpoint core configuration interface and the user TX/RX engines. It is the parametrised successor of the single-channel turn-off unit.

## Interface
- CH_NUM, 4, number of requester channels (1..16)
- CNT_W, 6, width of per-channel outstanding counter; saturates at 2^CNT_W-1
- TMO_W, 20, width of drain timeout counter
- TMO_CYCLES, 1000000, drain timeout in clk cycles; 0 disables the timeout (wait forever)
- clk  in  1  core clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- req_compl_i  in  CH_NUM  per-channel pulse: one request expecting a completion was issued
- compl_done_i  in  CH_NUM  per-channel pulse: one completion finished
- cfg_to_turnoff_n_i  in  1  low = PME_Turn_Off received, main power will be removed
- cfg_turnoff_ok_n_o  out  1  low for exactly one cycle = turn-off acknowledged
- quiesce_o  out  1  high = channels must not issue new requests
- pending_o  out  CH_NUM  bit i high = channel i counter nonzero
- tmo_o  out  1  sticky: last drain ended by timeout
- err_o  out  1  sticky: counter overflow or underflow seen on any channel
- state_o  out  2  current FSM state encoding (debug)

## Operation
- Per-channel counter: +1 on req_compl_i[i], -1 on compl_done_i[i], unchanged when both in the same cycle. Increment at max: hold, set err_o. Decrement at 0: hold, set err_o. Counters keep tracking in every state.
- pending_o[i] = (cnt[i] != 0), combinational from counter registers.
- FSM states: IDLE(0), DRAIN(1), ACK(2), OFF(3).
- IDLE: quiesce_o=0. cfg_to_turnoff_n_i low -> DRAIN; load timeout counter with TMO_CYCLES, clear tmo_o.
- DRAIN: quiesce_o=1. If pending_o all zero -> ACK. Else if TMO_CYCLES!=0 and timeout counter reaches 0 -> ACK, set tmo_o. Drained takes priority over timeout in the same cycle. cfg_to_turnoff_n_i returning high -> IDLE (request withdrawn, no ack).
- ACK: cfg_turnoff_ok_n_o=0 for this one cycle; next state OFF unconditionally.
- OFF: quiesce_o=1, cfg_turnoff_ok_n_o=1. Stays until cfg_to_turnoff_n_i high -> IDLE.
- err_o is cleared only by reset. tmo_o is cleared by reset or on entry to DRAIN.
- Reset values: all counters 0, state IDLE, cfg_turnoff_ok_n_o=1, quiesce_o=0, pending_o=0, tmo_o=0, err_o=0, state_o=0.

## Timing
- cfg_turnoff_ok_n_o, quiesce_o, tmo_o, err_o are registered outputs.
- cfg_to_turnoff_n_i falling edge sampled at cycle N -> quiesce_o high from N+1.
- With zero pending: cfg_turnoff_ok_n_o low in cycle N+2, high again in N+3.
- Last compl_done_i sampled at cycle M in DRAIN -> counter 0 at M+1 -> ok_n low at M+2.
- Timeout: ok_n low exactly TMO_CYCLES+2 cycles after request sampled, if still pending.
- Asynchronous reset mid-drain: immediate return to reset values; no ack is issued.

## Structure
- Shared package pcie_pm_pkg: FSM state encoding constants (S_IDLE..S_OFF), and default TMO_CYCLES constant.
- Sub-module pcie_compl_cnt: one saturating up/down counter with overflow/underflow flags, instantiated CH_NUM times in a generate loop. FSM and timeout counter live in the top.

## Test plan
- CH_NUM=4, no traffic, assert cfg_to_turnoff_n_i at cycle 10 -> quiesce_o=1 at 11, ok_n low only at cycle 12, state_o=3 afterwards; release -> IDLE, quiesce_o=0.
- 3 requests on ch2, turn-off asserted, completions at cycles 20/25/30 -> pending_o=4'b0100 until 31, ok_n low at 32, tmo_o=0.
- TMO_CYCLES=50, 1 request on ch0 never completed -> ok_n low at request+52, tmo_o=1, pending_o=4'b0001.
- Simultaneous req_compl_i and compl_done_i on ch1 with count 1 -> count stays 1; compl_done_i on ch3 at count 0 -> err_o=1, count 0.
- CNT_W=2, 4 requests on ch0 -> count saturates at 3, err_o=1.
- Deassert cfg_to_turnoff_n_i during DRAIN -> IDLE, no ok_n pulse. Separately, pulse rst_n low during DRAIN -> all outputs at reset values.

Source files
------------

// File: rtl/pcie_pm_pkg.sv
// Shared definitions for the PCIe power-management blocks:
// turn-off FSM state encoding and the default drain timeout.
package pcie_pm_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_ACK   = 2'd2,
    S_OFF   = 2'd3
  } pm_state_e;

  localparam int unsigned TMO_CYCLES_DEF = 32'd1000000;

endpackage

// File: rtl/pcie_compl_cnt.sv
// Saturating up/down counter of outstanding non-posted completions for one
// requester channel; flags an overflow or underflow attempt in the same cycle.
module pcie_compl_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_up;
  logic             w_dn;

  // Simultaneous issue and completion cancel out.
  always_comb begin
    w_up  = inc_i & ~dec_i;
    w_dn  = dec_i & ~inc_i;
    ovf_o = w_up & (r_cnt == CNT_MAX);
    unf_o = w_dn & (r_cnt == CNT_ZERO);
  end

  // Counter holds at its limits instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (w_up && !ovf_o) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else if (w_dn && !unf_o) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pcie_turnoff_ctrl.sv
// Multi-channel PCIe turn-off controller: quiesces requesters on PME_Turn_Off
// and acknowledges once all channels drain or the drain timeout expires.
module pcie_turnoff_ctrl
  import pcie_pm_pkg::*;
#(
  parameter int          CH_NUM     = 4,
  parameter int          CNT_W      = 6,
  parameter int          TMO_W      = 20,
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] req_compl_i,
  input  logic [CH_NUM-1:0] compl_done_i,
  input  logic              cfg_to_turnoff_n_i,
  output logic              cfg_turnoff_ok_n_o,
  output logic              quiesce_o,
  output logic [CH_NUM-1:0] pending_o,
  output logic              tmo_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYCLES);
  localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam bit               TMO_EN   = (TMO_CYCLES != 32'd0);

  logic [CNT_W-1:0]  w_cnt [CH_NUM];
  logic [CH_NUM-1:0] w_ovf;
  logic [CH_NUM-1:0] w_unf;
  logic              w_err_any;
  logic              w_drained;

  pm_state_e         r_state;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_ok_n;
  logic              r_quiesce;
  logic              r_tmo;
  logic              r_err;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    pcie_compl_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (req_compl_i[g]),
      .dec_i (compl_done_i[g]),
      .cnt_o (w_cnt[g]),
      .ovf_o (w_ovf[g]),
      .unf_o (w_unf[g])
    );
    assign pending_o[g] = |w_cnt[g];
  end

  assign w_err_any = |(w_ovf | w_unf);
  assign w_drained = (pending_o == {CH_NUM{1'b0}});

  // Turn-off FSM with drain timer; a withdrawn request beats any pending ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= TMO_ZERO;
      r_ok_n    <= 1'b1;
      r_quiesce <= 1'b0;
      r_tmo     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ok_n <= 1'b1;
      if (w_err_any) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (!cfg_to_turnoff_n_i) begin
            r_state   <= S_DRAIN;
            r_quiesce <= 1'b1;
            r_tmo_cnt <= TMO_LOAD;
            r_tmo     <= 1'b0;
          end else begin
            r_quiesce <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (cfg_to_turnoff_n_i) begin
            r_state   <= S_IDLE;
            r_quiesce <= 1'b0;
          end else if (w_drained) begin
            r_state <= S_ACK;
            r_ok_n  <= 1'b0;
          end else if (TMO_EN && (r_tmo_cnt == TMO_ZERO)) begin
            r_state <= S_ACK;
            r_ok_n  <= 1'b0;
            r_tmo   <= 1'b1;
          end else if (r_tmo_cnt != TMO_ZERO) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_ONE;
          end
        end
        S_ACK: begin
          r_state <= S_OFF;
        end
        S_OFF: begin
          if (cfg_to_turnoff_n_i) begin
            r_state   <= S_IDLE;
            r_quiesce <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_quiesce <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_turnoff_ok_n_o = r_ok_n;
  assign quiesce_o          = r_quiesce;
  assign tmo_o              = r_tmo;
  assign err_o              = r_err;
  assign state_o            = r_state;

endmodule
